// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and limits shared by the multiply/divide unit
package mdu_pkg;

    localparam int MUL_LAT_MAX = 15;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV_LOAD,
        ST_DIV_ITER,
        ST_DIV_FIX
    } state_e;

endpackage

// File: rtl/div_core.sv
// div_core: unsigned restoring divider, one quotient bit per cycle, WIDTH cycles
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             run;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    assign trial = {remainder, quotient[WIDTH-1]};
    assign diff  = trial - {1'b0, dvs};

    // load operands on start, then shift-subtract; a borrow in diff means restore
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run       <= 1'b0;
            cnt       <= '0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                run <= 1'b0;
            end else if (start) begin
                run       <= 1'b1;
                cnt       <= CW'(WIDTH);
                dvs       <= divisor;
                quotient  <= dividend;
                remainder <= '0;
            end else if (run) begin
                remainder <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], ~diff[WIDTH]};
                cnt       <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO engine owning HI/LO
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             rd_hi,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2((WIDTH > MUL_LAT_MAX ? WIDTH : MUL_LAT_MAX) + 1);

    state_e             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   opa, opb, mag_a, mag_b, quo, rem, quo_fix, rem_fix;
    logic               sgn, neg_a, neg_b, mul_sgn, div_done;

    assign mul_sgn = (op == MD_MULT);
    assign neg_a   = sgn & opa[WIDTH-1];
    assign neg_b   = sgn & opb[WIDTH-1];
    assign mag_a   = neg_a ? -opa : opa;
    assign mag_b   = neg_b ? -opb : opb;
    assign quo_fix = (neg_a ^ neg_b) ? -quo : quo;
    assign rem_fix = neg_a ? -rem : rem;
    assign busy    = (state != ST_IDLE);
    assign stall   = busy | (start & ~cancel & (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}));
    assign rd_data = rd_hi ? hi : lo;

    div_core #(.WIDTH(WIDTH)) u_div (
        .clk(clk),
        .reset(reset),
        .start(state == ST_DIV_LOAD),
        .cancel(cancel),
        .dividend(mag_a),
        .divisor(mag_b),
        .quotient(quo),
        .remainder(rem),
        .done(div_done)
    );

    // control FSM: issue, latency counting, sign fix-up and HI/LO write-back; cancel wins over all
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            prod  <= '0;
            opa   <= '0;
            opb   <= '0;
            sgn   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (start) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                prod  <= {{WIDTH{mul_sgn & a[WIDTH-1]}}, a} *
                                         {{WIDTH{mul_sgn & b[WIDTH-1]}}, b};
                                cnt   <= CW'(MUL_LAT);
                                state <= ST_MUL;
                            end
                            MD_DIV, MD_DIVU: begin
                                opa   <= a;
                                opb   <= b;
                                sgn   <= (op == MD_DIV);
                                state <= ST_DIV_LOAD;
                            end
                            MD_MTHI: hi <= a;
                            MD_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                    ST_MUL: begin
                        if (cnt == CW'(1)) begin
                            {hi, lo} <= prod;
                            done     <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_DIV_LOAD: begin
                        cnt   <= CW'(WIDTH);
                        state <= ST_DIV_ITER;
                    end
                    ST_DIV_ITER: begin
                        if (cnt == CW'(1)) state <= ST_DIV_FIX;
                        else cnt <= cnt - 1'b1;
                    end
                    ST_DIV_FIX: if (div_done) begin
                        lo    <= (opb == '0) ? '1 : quo_fix;
                        hi    <= (opb == '0) ? opa : rem_fix;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with a done-driven scoreboard for mul_div_unit
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0, reset = 1'b0, start = 1'b0, cancel = 1'b0, rd_hi = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] rd_data, hi, lo;
    logic         busy, stall, done;

    int checks = 0;
    int failures = 0;
    logic [2*W-1:0] exp_q[$];

    mul_div_unit #(.WIDTH(W), .MUL_LAT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .rd_hi(rd_hi), .rd_data(rd_data), .busy(busy),
        .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, output logic s);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1; cancel = c;
        #1 s = stall;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // scoreboard monitor: every done pulse must match the oldest expected {hi,lo}
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done hi=%h lo=%h required=no done pulse", hi, lo);
            end else begin
                chk("result_hi_lo", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic s;
        int n;
        #1 reset = 1'b1;
        #1;
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
        issue(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, s);
        chk("mult_stall", s, 1);
        wait_idle(n);
        chk("mult_busy_cycles", n, 4);
        rd_hi = 1'b1; #1 chk("rd_data_hi", rd_data, 32'hFFFFFFFF);
        rd_hi = 1'b0; #1 chk("rd_data_lo", rd_data, 32'hFFFFFFFA);

        exp_q.push_back({32'h00000002, 32'hFFFFFFFA});
        issue(MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, s);
        wait_idle(n);
        chk("multu_busy_cycles", n, 4);

        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, s);
        chk("div_stall", s, 1);
        wait_idle(n);
        chk("div_busy_cycles", n, 34);

        exp_q.push_back({32'd1, 32'd3});
        issue(MD_DIVU, 32'd7, 32'd2, 1'b0, s);
        wait_idle(n);
        exp_q.push_back({32'd5, 32'hFFFFFFFF});
        issue(MD_DIV, 32'd5, 32'd0, 1'b0, s);
        wait_idle(n);
        chk("divzero_busy_cycles", n, 34);
        exp_q.push_back({32'd0, 32'h80000000});
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, s);
        wait_idle(n);
        exp_q.push_back({32'd1, 32'hFFFFFFFD});
        issue(MD_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, s);
        wait_idle(n);
        exp_q.push_back({32'd2, 32'd14});
        issue(MD_DIVU, 32'd100, 32'd7, 1'b0, s);
        wait_idle(n);

        issue(MD_MTHI, 32'h11, 32'd0, 1'b0, s);
        chk("mthi_stall", s, 0);
        chk("mthi_hi", hi, 32'h11);
        chk("mthi_busy", busy, 0);
        issue(MD_MTLO, 32'h22, 32'd0, 1'b0, s);
        chk("mtlo_lo", lo, 32'h22);

        issue(MD_DIVU, 32'd100, 32'd7, 1'b0, s);
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        #1 chk("cancel_busy_stall", stall, 1);
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", busy, 0);
        chk("cancel_hi", hi, 32'h11);
        chk("cancel_lo", lo, 32'h22);
        repeat (40) @(negedge clk);
        chk("cancel_hi_later", hi, 32'h11);

        issue(MD_MULT, 32'd3, 32'd3, 1'b1, s);
        chk("cancel_start_stall", s, 0);
        chk("cancel_start_busy", busy, 0);
        issue(MD_MTHI, 32'h99, 32'd0, 1'b1, s);
        chk("cancel_mthi_hi", hi, 32'h11);

        issue(MD_MTHI, 32'hABCD, 32'd0, 1'b0, s);
        chk("mthi_abcd", hi, 32'hABCD);
        chk("mthi_abcd_busy", busy, 0);
        exp_q.push_back({32'd0, 32'd6});
        issue(MD_MULT, 32'd2, 32'd3, 1'b0, s);
        issue(MD_MTLO, 32'h5555, 32'd0, 1'b0, s);
        chk("mtlo_busy_stall", s, 1);
        chk("mtlo_busy_lo", lo, 32'h22);
        rd_hi = 1'b1; #1 chk("rd_data_busy", rd_data, 32'hABCD);
        wait_idle(n);
        chk("mult_after_mtlo_lo", lo, 32'd6);

        issue(3'd6, 32'd1, 32'd1, 1'b0, s);
        chk("reserved_stall", s, 0);
        chk("reserved_busy", busy, 0);
        chk("reserved_hi_lo", {hi, lo}, {32'd0, 32'd6});

        issue(MD_MTHI, 32'h77, 32'd0, 1'b0, s);
        issue(MD_DIV, 32'd100, 32'd7, 1'b0, s);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_hi", hi, 0);
        chk("async_reset_lo", lo, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back({32'd0, 32'd42});
        issue(MD_MULT, 32'd7, 32'd6, 1'b0, s);
        wait_idle(n);
        chk("mult_after_reset_cycles", n, 4);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
